if_fetch_queue: RTL

Parametrised instruction-fetch front end that replaces the single-entry skid buffer between the instruction memory and the DC stage with a DEPTH-entry fetch queue. It issues sequential/predicted fetches to a 1-cycle-latency IM, tags each in-flight request with its PC and predicted-jump bit, and buffers returned instructions for DC under a valid/ready handshake. A mispredict redirect flushes the queue and the in-flight response in one cycle and restarts fetch at the corrected PC.

---
 rtl/if_fetch_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential/predicted fetches to a 1-cycle IM
// and buffers returned instructions in a DEPTH-entry queue toward DC.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            bp_pc,
    input  logic [XLEN-1:0]            bp_next_pc,
    input  logic                       bp_next_jump,
    output logic [XLEN-1:0]            IM_r_addr,
    output logic                       IM_ready,
    input  logic [XLEN-1:0]            IM_r_data,
    input  logic                       mispredict,
    input  logic [XLEN-1:0]            jb_pc,
    output logic [XLEN-1:0]            IF_out_pc,
    output logic [XLEN-1:0]            IF_out_inst,
    output logic                       IF_out_jump,
    output logic                       IF_valid,
    input  logic                       DC_ready,
    output logic [$clog2(DEPTH+1)-1:0] if_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic            ifl_valid;
    logic [XLEN-1:0] ifl_pc;
    logic            ifl_jump;

    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [XLEN-1:0] q_inst [DEPTH];
    logic            q_jump [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [CW:0]     occupied;
    logic            credit_ok;
    logic            push;
    logic            pop;

    // In-flight request reserves a slot; a same-cycle pop is deliberately not credited.
    assign occupied  = {1'b0, count} + {{CW{1'b0}}, ifl_valid};
    assign credit_ok = occupied < (CW+1)'(DEPTH);

    assign IM_r_addr = mispredict ? jb_pc : pc;
    assign bp_pc     = IM_r_addr;
    assign IM_ready  = !rst && (mispredict || credit_ok);

    assign IF_valid  = (count != '0) && !mispredict;
    assign push      = ifl_valid && !mispredict;
    assign pop       = IF_valid && DC_ready;
    assign if_count  = count;

    assign IF_out_pc   = IF_valid ? q_pc[rd_ptr]   : '0;
    assign IF_out_inst = IF_valid ? q_inst[rd_ptr] : '0;
    assign IF_out_jump = IF_valid ? q_jump[rd_ptr] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ifl_valid <= 1'b0;
            ifl_pc    <= '0;
            ifl_jump  <= 1'b0;
        end else if (IM_ready) begin
            pc        <= bp_next_pc;
            ifl_valid <= 1'b1;
            ifl_pc    <= IM_r_addr;
            ifl_jump  <= bp_next_jump;
        end else begin
            ifl_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= ifl_pc;
            q_inst[wr_ptr] <= IM_r_data;
            q_jump[wr_ptr] <= ifl_jump;
        end
    end

endmodule
